// File: rtl/gcd_master.sv
// Upstream sequencer for the gcd FSMD: takes an operand pair on valid/ready,
// runs the 4-phase req/ack exchange on the shared AB bus and returns C on valid/ready.
module gcd_master #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             req,
    output logic [WIDTH-1:0] AB,
    input  logic             ack,
    input  logic [WIDTH-1:0] C,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SEND_A = 3'd1;
    localparam logic [2:0] REL_A  = 3'd2;
    localparam logic [2:0] SEND_B = 3'd3;
    localparam logic [2:0] REL_B  = 3'd4;
    localparam logic [2:0] OUT    = 3'd5;

    logic [2:0]       state_q,     state_d;
    logic             req_q,       req_d;
    logic [WIDTH-1:0] ab_q,        ab_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q,  res_data_d;
    logic             res_err_q,   res_err_d;
    logic [CNT_W-1:0] op_count_q,  op_count_d;

    // Next-state and datapath decode for the sequencer.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        ab_d        = ab_q;
        b_d         = b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        op_count_d  = op_count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // A zero operand would make gcd subtract forever: answer locally.
                    if ((in_a == '0) || (in_b == '0)) begin
                        res_data_d  = '0;
                        res_err_d   = 1'b1;
                        res_valid_d = 1'b1;
                        state_d     = OUT;
                    end else begin
                        b_d     = in_b;
                        ab_d    = in_a;
                        req_d   = 1'b1;
                        state_d = SEND_A;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SEND_A: begin
                if (ack) begin
                    req_d   = 1'b0;
                    state_d = REL_A;
                end else begin
                    req_d = 1'b1;
                end
            end
            REL_A: begin
                if (!ack) begin
                    ab_d    = b_q;
                    req_d   = 1'b1;
                    state_d = SEND_B;
                end else begin
                    req_d = 1'b0;
                end
            end
            SEND_B: begin
                if (ack) begin
                    res_data_d = C;
                    res_err_d  = 1'b0;
                    req_d      = 1'b0;
                    state_d    = REL_B;
                end else begin
                    req_d = 1'b1;
                end
            end
            REL_B: begin
                if (!ack) begin
                    res_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    req_d = 1'b0;
                end
            end
            OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    state_d     = IDLE;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                req_d       = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            ab_q        <= '0;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            ab_q        <= ab_d;
            b_q         <= b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            op_count_q  <= op_count_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign req       = req_q;
    assign AB        = ab_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_gcd_master.sv
// Bench for gcd_master against a behavioural gcd responder; results are checked
// through a scoreboard queue filled at accept time and drained at the output handshake.
module tb_gcd_master;

    localparam int WIDTH = 16;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             req;
    logic [WIDTH-1:0] AB;
    logic             ack;
    logic [WIDTH-1:0] C;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_err;
    logic [CNT_W-1:0] op_count;

    int n_tests = 0;
    int n_fail  = 0;
    int extra_delay = 0;
    int viol_rise = 0;
    int viol_ab   = 0;

    logic [WIDTH:0]   exp_q[$];
    logic [CNT_W-1:0] exp_count;

    gcd_master #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .req(req), .AB(AB), .ack(ack), .C(C),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result: {err, data}, by repeated subtraction.
    function automatic logic [WIDTH:0] exp_of(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        if (a == 16'd0 || b == 16'd0) return {1'b1, 16'd0};
        x = a;
        y = b;
        while (x != y) begin
            if (x > y) x = x - y;
            else       y = y - x;
        end
        return {1'b0, x};
    endfunction

    // Behavioural gcd responder: samples AB one cycle after seeing req, Euclid per cycle.
    logic [2:0]       g_st;
    logic [WIDTH-1:0] ga, gb;
    int               dly;
    always @(posedge clk) begin
        if (reset) begin
            g_st <= 3'd0; ack <= 1'b0; C <= 16'd0; ga <= 16'd0; gb <= 16'd0; dly <= 0;
        end else begin
            case (g_st)
                3'd0: if (req) g_st <= 3'd1;
                3'd1: begin ga <= AB; ack <= 1'b1; g_st <= 3'd2; end
                3'd2: if (!req) begin ack <= 1'b0; g_st <= 3'd3; end
                3'd3: if (req) g_st <= 3'd4;
                3'd4: begin gb <= AB; dly <= extra_delay; g_st <= 3'd5; end
                3'd5: begin
                    if (dly != 0) dly <= dly - 1;
                    else if (gb == 16'd0) begin C <= ga; ack <= 1'b1; g_st <= 3'd6; end
                    else begin ga <= gb; gb <= ga % gb; end
                end
                3'd6: if (!req) begin ack <= 1'b0; C <= 16'd0; g_st <= 3'd0; end
                default: g_st <= 3'd0;
            endcase
        end
    end

    // Output scoreboard plus handshake-rule monitor, sampled on the falling edge.
    logic             prev_req = 1'b0;
    logic             prev_ack = 1'b0;
    logic [WIDTH-1:0] prev_ab  = 16'd0;
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp_count = 3'd0;
        end else begin
            if (req && !prev_req && prev_ack) viol_rise++;
            if (req && prev_req && (AB != prev_ab)) viol_ab++;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    logic [WIDTH:0] e;
                    e = exp_q.pop_front();
                    check("res_data", res_data, e[WIDTH-1:0]);
                    check("res_err", res_err, e[WIDTH]);
                    check("op_count", op_count, exp_count);
                    exp_count = exp_count + 3'd1;
                end
            end
        end
        prev_req = req;
        prev_ack = ack;
        prev_ab  = AB;
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1'b1);
        end else begin
            in_a = a;
            in_b = b;
            in_valid = 1'b1;
            exp_q.push_back(exp_of(a, b));
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_send_b(input logic [WIDTH-1:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!(req && AB == b && !in_ready && prev_req) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_send_b", (req && AB == b), 1'b1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_a = 16'd0; in_b = 16'd0; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req", req, 1'b0);
        check("rst_ab", AB, 16'd0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_data", res_data, 16'd0);
        check("rst_res_err", res_err, 1'b0);
        check("rst_op_count", op_count, 3'd0);
        check("rst_in_ready", in_ready, 1'b1);
        reset = 1'b0;

        // 1: basic pair
        send(16'd12, 16'd18);
        drain();
        check("count_after_1", op_count, 3'd1);

        // 2: long compute, bus held while gcd works
        extra_delay = 300;
        send(16'hFFFF, 16'd1);
        wait_send_b(16'd1);
        repeat (100) @(negedge clk);
        check("long_req", req, 1'b1);
        check("long_ab", AB, 16'd1);
        check("long_busy", in_ready, 1'b0);
        drain();
        extra_delay = 0;

        // 3: zero operand answered in one cycle without a handshake
        send(16'd0, 16'd7);
        @(negedge clk);
        check("zero_lat_valid", res_valid, 1'b1);
        check("zero_no_req", req, 1'b0);
        drain();

        // 4: A==B with a stalled consumer
        res_ready = 1'b0;
        send(16'd9, 16'd9);
        begin
            int n;
            n = 0;
            while (!res_valid && n < 200) begin @(negedge clk); n++; end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", res_valid, 1'b1);
            check("hold_data", res_data, 16'd9);
            check("hold_in_ready", in_ready, 1'b0);
        end
        res_ready = 1'b1;
        drain();

        // 5: reset while the master drives B
        send(16'd40, 16'd24);
        wait_send_b(16'd24);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_req", req, 1'b0);
        check("mid_rst_idle", in_ready, 1'b1);
        check("mid_rst_count", op_count, 3'd0);
        @(negedge clk);
        reset = 1'b0;
        send(16'd35, 16'd21);
        drain();

        // 6: back-to-back pairs
        send(16'd8, 16'd12);
        send(16'd17, 16'd5);
        send(16'd100, 16'd75);
        drain();

        // rejected pairs count too; op_count wraps
        for (int i = 1; i <= 5; i++) begin
            if (i % 2 == 0) send(16'd0, 16'(i));
            else            send(16'(i), 16'd0);
        end
        drain();
        check("count_wrap", op_count, 3'd1);

        check("hs_req_rise", viol_rise, 32'd0);
        check("hs_ab_stable", viol_ab, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
